arbitro_rr_4: RTL and testbench
===============================

ARBITRO_RR_4 -- requirements
Module: arbitro_rr_4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum consecutive cycles one grant is held (legal range 1..255).
REQ-002 The block SHALL have a single clock; reset is asynchronous and active-high.
REQ-003 Port clk, input, 1, clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port en, input, 1, arbitration enable; en=0 blocks new grants and revokes any current grant.
REQ-006 Port req, input, 4, request lines; req[i]=1 means requester i wants the shared resource.
REQ-007 Port done, input, 1, release strobe from the current owner.
REQ-008 Port gnt, output, 4, registered one-hot grant produced by decoding gnt_idx; all zero when no grant is active.
REQ-009 Port gnt_idx, output, 2, index of the current or last granted requester.
REQ-010 Port busy, output, 1, high while a grant is active (busy == |gnt).
REQ-011 Port timeout, output, 1, one-cycle pulse marking a grant revoked by the hold limit.

Function
REQ-012 The FSM SHALL have two states: IDLE (gnt=0000) and GRANT (gnt = one-hot of gnt_idx).
REQ-013 The block SHALL keep a 2-bit priority pointer ptr equal to the last granted index; the search order SHALL be ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-014 In IDLE with en=1 and req!=0000, the block SHALL load gnt_idx with the first requesting index in search order, set ptr to that index, and enter GRANT, so gnt is valid on the next clock edge (1-cycle latency).
REQ-015 In IDLE with en=0 or req=0000, the block SHALL remain in IDLE and leave gnt_idx and ptr unchanged.
REQ-016 The block SHALL use a hold counter cleared on entry to GRANT and incremented each GRANT cycle; its width SHALL be 8 bits.
REQ-017 In GRANT, the release priority SHALL be: en=0, then done=1 or req[gnt_idx]=0, then hold counter == MAX_HOLD-1; the first condition that is true SHALL return the FSM to IDLE on the next edge.
REQ-018 A grant not released earlier SHALL stay asserted for exactly MAX_HOLD cycles.
REQ-019 timeout SHALL be 1 in the cycle after release only when the hold limit was the sole release cause; otherwise it SHALL be 0.
REQ-020 After every release, the block SHALL spend at least one cycle in IDLE (gnt=0000) before the next grant; back-to-back grants without this dead cycle SHALL NOT occur.
REQ-021 Requests that change while a grant is held SHALL NOT alter gnt or gnt_idx until release.
REQ-022 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-023 While rst=1, the block SHALL force state=IDLE, gnt=0000, gnt_idx=00, busy=0, timeout=0, hold counter=0 and ptr=11, so requester 0 has first priority after reset.
REQ-024 Assertion of rst mid-grant SHALL clear gnt immediately, with no clock edge required.

Verification
REQ-025 Release rst; en=1, req=0001 -> next edge gnt=0001, gnt_idx=00, busy=1; pulse done -> gnt=0000 next edge.
REQ-026 req=1111 held, done pulsed on every grant cycle -> grant sequence 0001,0010,0100,1000,0001, each separated by one gnt=0000 cycle.
REQ-027 MAX_HOLD=8; req=0011 held, no done -> gnt=0001 for exactly 8 cycles; timeout=1 on the following cycle; the next grant is 0010.
REQ-028 Grant active on req2; en driven 0 -> gnt=0000 next edge, timeout=0; en back to 1 with req=0100 -> gnt=0100 again.
REQ-029 done=1 on the same cycle the hold counter reaches MAX_HOLD-1 -> release occurs and timeout stays 0.
REQ-030 rst pulsed while gnt=1000 -> gnt=0000 asynchronously; afterwards req=1001 -> gnt=0001 first.

Source files
------------

// File: rtl/arbitro_rr_4.sv
// Four-way round-robin arbiter. A grant is held until the owner releases it or
// drops its request, the enable falls, or the hold limit expires.
//
// Handshake: a requester holds req[i] high until it sees gnt[i], then keeps it
// high for as long as it needs the resource. It releases the resource by
// pulsing done or by dropping req[i]. gnt is registered, and every grant is
// followed by at least one idle cycle with gnt == 0.
module arbitro_rr_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       busy,
  output logic       timeout,
  output logic       dbg_state_o,
  output logic [1:0] dbg_ptr_o,
  output logic [7:0] dbg_hold_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q;
  logic [3:0] gnt_q;
  logic [1:0] gnt_idx_q;
  logic [1:0] ptr_q;
  logic [7:0] hold_q;
  logic       busy_q;
  logic       timeout_q;

  logic [1:0] gnt_idx_d;
  logic       pick_vld;
  logic [1:0] cand;
  logic       rel_en;
  logic       rel_own;
  logic       rel_hold;
  logic       release_d;
  logic       timeout_d;

  // Search ptr+1, ptr+2, ptr+3, then ptr itself, so the last owner goes last.
  always_comb begin
    gnt_idx_d = ptr_q;
    pick_vld  = 1'b0;
    cand      = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!pick_vld && req[cand]) begin
        pick_vld  = 1'b1;
        gnt_idx_d = cand;
      end
    end
  end

  // Release causes, highest priority first; timeout only when the limit alone fired.
  always_comb begin
    rel_en    = !en;
    rel_own   = done || !req[gnt_idx_q];
    rel_hold  = (hold_q == HOLD_LAST);
    release_d = rel_en || rel_own || rel_hold;
    timeout_d = !rel_en && !rel_own && rel_hold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      gnt_idx_q <= 2'b00;
      ptr_q     <= 2'b11;
      hold_q    <= 8'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en && pick_vld) begin
            state_q   <= GRANT;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= gnt_idx_d;
            gnt_q     <= 4'b0001 << gnt_idx_d;
            busy_q    <= 1'b1;
            hold_q    <= 8'd0;
          end
        end
        GRANT: begin
          if (release_d) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            busy_q    <= 1'b0;
            hold_q    <= 8'd0;
            timeout_q <= timeout_d;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign gnt_idx     = gnt_idx_q;
  assign busy        = busy_q;
  assign timeout     = timeout_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;
  assign dbg_hold_o  = hold_q;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_busy_match: assert property (@(posedge clk) disable iff (rst) busy_q == (gnt_q != 4'b0000));

endmodule

// File: tb/tb_arbitro_rr_4.sv
// Directed bench for arbitro_rr_4: the drivers queue the expected outputs for
// each cycle, and a monitor pops and compares them after every rising edge.
module tb_arbitro_rr_4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       done = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;
  logic       dbg_state_o;
  logic [1:0] dbg_ptr_o;
  logic [7:0] dbg_hold_o;

  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int mon_n   = 0;

  arbitro_rr_4 #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .timeout(timeout),
    .dbg_state_o(dbg_state_o), .dbg_ptr_o(dbg_ptr_o), .dbg_hold_o(dbg_hold_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] snap();
    return {gnt, gnt_idx, busy, timeout};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {gnt,idx,busy,to}=%b, want %b", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [7:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("cyc%0d", mon_n), snap(), e);
      mon_n++;
    end
  end

  // driver tasks
  task automatic cyc(input logic e, input logic [3:0] r, input logic d,
                     input logic [3:0] g, input logic [1:0] gi, input logic to);
    @(negedge clk);
    en   = e;
    req  = r;
    done = d;
    exp_q.push_back({g, gi, (g != 4'b0000), to});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    en   = 1'b0;
    req  = 4'b0000;
    done = 1'b0;
    rst  = 1'b1;
    #1;
    check("rst_out", snap(), 8'h00);
    check("rst_ptr", {6'b0, dbg_ptr_o}, 8'h03);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] seq_b_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] seq_b_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] pat_e     [7] = '{4'b0001, 4'b1111, 4'b0011, 4'b0101, 4'b1001, 4'b0111, 4'b1101};

  initial begin
    repeat (2) @(negedge clk);
    check("init_out", snap(), 8'h00);
    check("init_ptr", {6'b0, dbg_ptr_o}, 8'h03);
    rst = 1'b0;

    // single requester, release by done
    cyc(1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc(1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // full rotation with done every cycle
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 4'b1111, 1'b1, seq_b_gnt[k], seq_b_idx[k], 1'b0);
      cyc(1'b1, 4'b1111, 1'b1, 4'b0000, seq_b_idx[k], 1'b0);
    end
    cyc(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // hold limit expiry, then rotation to requester 1
    apply_reset();
    for (int k = 0; k < 8; k++) cyc(1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc(1'b1, 4'b0011, 1'b0, 4'b0000, 2'd0, 1'b1);
    cyc(1'b1, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0);
    cyc(1'b1, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0);
    cyc(1'b0, 4'b0011, 1'b0, 4'b0000, 2'd1, 1'b0);

    // enable drop revokes the grant on requester 2
    cyc(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
    cyc(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
    cyc(1'b0, 4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0);
    cyc(1'b0, 4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0);
    cyc(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
    cyc(1'b1, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0);

    // done coincides with the hold limit; other requests change meanwhile
    cyc(1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    for (int k = 0; k < 7; k++) cyc(1'b1, pat_e[k], 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // enable drop coincides with the hold limit
    for (int k = 0; k < 8; k++) cyc(1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc(1'b0, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0);

    // request drop coincides with the hold limit
    for (int k = 0; k < 8; k++) cyc(1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // asynchronous reset in the middle of a grant on requester 3
    cyc(1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", snap(), 8'h00);
    en  = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc(1'b1, 4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0);
    cyc(1'b1, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0);
    cyc(1'b1, 4'b1001, 1'b1, 4'b0000, 2'd3, 1'b0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
